// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               datapath width, instruction size, FSM state encoding and
//               small PC helper functions.
//               The HALT state exists only when FETCH_MISALIGN_CHECK_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {
        S_ISSUE = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;
`else
    typedef enum logic [2:0] {
        S_ISSUE = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3
    } fetch_state_t;
`endif

    // Sequential successor; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

    // Forces a redirect address onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] tgt);
        return {tgt[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_hold_buf
// Description : Holding register for the instruction handed to decode.
//               Load captures an instruction and its address and raises
//               valid; clear drops valid (data is left in place).
//               Load has priority over clear.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_load        - capture i_instr/i_pc, set o_valid
//               i_clear       - drop o_valid
//               i_instr, i_pc - instruction word and its address
//               o_valid, o_instr, o_pc - held contents
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch unit. Issues one-cycle
//               requests to instruction memory, holds the returned
//               instruction for decode, and redirects on taken branches,
//               discarding any in-flight or held instruction.
// Parameters  : RESET_PC - first fetch address after reset
// Macro       : FETCH_MISALIGN_CHECK_EN - when defined, a taken branch to a
//               non word-aligned target sets the sticky misalign_err flag
//               and halts fetch until reset; when undefined, the target's
//               low two bits are dropped and misalign_err is tied low.
// Ports       : clk, rst                        - clock, async active-high reset
//               branch_control                  - branch condition result
//               branch_instruction_control      - executing instruction is B-type
//               branch_target                   - redirect address
//               imem_req, imem_addr             - fetch request / address
//               imem_valid, imem_rdata          - memory response
//               if_valid, if_instr, if_pc       - instruction offered to decode
//               id_ready                        - decode accepts
//               flush                           - pulse, cycle after a redirect
//               misalign_err                    - sticky misaligned-target flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_control,
    input  logic            branch_instruction_control,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready,
    output logic            flush,
    output logic            misalign_err
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_flush;

    logic            w_branch_taken;
    logic            w_redirect;     // taken branch that actually moves the pc
    logic            w_halt;         // taken branch to a bad target (checked build only)
    logic [XLEN-1:0] w_target;
    logic            w_load;
    logic            w_clear;

    assign w_branch_taken = branch_control && branch_instruction_control;
    assign w_target       = align_target(branch_target);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    // Once halted, branches are ignored entirely until reset.
    assign w_halt     = w_branch_taken && (branch_target[1:0] != 2'b00) && (r_state != S_HALT);
    assign w_redirect = w_branch_taken && (branch_target[1:0] == 2'b00) && (r_state != S_HALT);
    assign misalign_err = r_misalign;
`else
    assign w_halt       = 1'b0;
    assign w_redirect   = w_branch_taken;
    assign misalign_err = 1'b0;
`endif

    // Requests are suppressed in a branch cycle so the old pc never escapes.
    assign imem_req  = !rst && (r_state == S_ISSUE) && !w_branch_taken;
    assign imem_addr = r_pc;

    // A response arriving together with a branch belongs to the wrong path.
    assign w_load  = (r_state == S_WAIT) && imem_valid && !w_branch_taken;
    // The buffer can only be valid in HOLD, so clearing there covers accept,
    // redirect and halt alike.
    assign w_clear = (r_state == S_HOLD) && (id_ready || w_branch_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ISSUE;
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_flush <= w_redirect;
            case (r_state)
                S_ISSUE: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (!w_branch_taken) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        // Still owed a response unless it is arriving now.
                        r_state <= imem_valid ? S_ISSUE : S_DRAIN;
                    end else if (w_load) begin
                        r_pc    <= next_pc(r_pc);
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= S_ISSUE;
                    end else if (id_ready) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (imem_valid) begin
                        r_state <= S_ISSUE;
                    end
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                S_HALT: begin
                    r_state <= S_HALT;
                end
`endif
                default: begin
                    r_state <= S_ISSUE;
                end
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            // Overrides whatever the state arm chose; pc is left untouched.
            if (w_halt) begin
                r_misalign <= 1'b1;
                r_state    <= S_HALT;
            end
`endif
        end
    end

    assign flush = r_flush;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_instr (imem_rdata),
        .i_pc    (r_pc),
        .o_valid (if_valid),
        .o_instr (if_instr),
        .o_pc    (if_pc)
    );

    // Only meaningful to the halt logic; otherwise the low bits are dropped.
    logic w_unused_halt;
    assign w_unused_halt = w_halt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. A second
//               instance with RESET_PC = 0xFFFF_FFFC runs in lockstep to
//               exercise the pc wrap. A cycle-level memory model answers
//               each request after a programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_KEY = 32'hA5A5_0000;  // rdata = addr ^ C_KEY

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_control;
    logic        branch_instruction_control;
    logic [31:0] branch_target;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        id_ready;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic        if_valid,  if_valid2;
    logic [31:0] if_instr,  if_instr2;
    logic [31:0] if_pc,     if_pc2;
    logic        flush,     flush2;
    logic        misalign_err, misalign_err2;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat      = 2;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    logic        inject   = 1'b0;
    logic        req_q;
    logic [31:0] addr_q, addr2_q, issue_addr2;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
        .clk(clk), .rst(rst),
        .branch_control(branch_control),
        .branch_instruction_control(branch_instruction_control),
        .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .misalign_err(misalign_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .branch_control(branch_control),
        .branch_instruction_control(branch_instruction_control),
        .branch_target(branch_target),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
        .id_ready(id_ready), .flush(flush2), .misalign_err(misalign_err2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: memory response, input drive, then sample of the
    // combinational request (which is also handed to the memory model).
    task automatic cycle(input logic bc, input logic bic, input logic [31:0] tgt, input logic rdy);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_valid = 1'b0;
        if (inject) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            inject     = 1'b0;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_addr ^ C_KEY;
            end
        end
        branch_control             = bc;
        branch_instruction_control = bic;
        branch_target              = tgt;
        id_ready                   = rdy;
        #1;
        req_q   = imem_req;
        addr_q  = imem_addr;
        addr2_q = imem_addr2;
        if (imem_req) begin
            mem_cnt  = lat;
            mem_addr = imem_addr;
        end
    endtask

    // Finish a fetch whose request cycle has already happened.
    task automatic complete(input logic [31:0] a, input logic rdy, input logic bc);
        repeat (lat) cycle(bc, 1'b0, 32'h0000_0500, rdy);
        check("valid_lag", if_valid, 0);
        cycle(bc, 1'b0, 32'h0000_0500, rdy);
        check("if_valid", if_valid, 1);
        check("if_pc", if_pc, a);
        check("if_instr", if_instr, a ^ C_KEY);
    endtask

    task automatic fetch(input logic [31:0] a, input logic rdy, input logic bc);
        cycle(bc, 1'b0, 32'h0000_0500, rdy);
        check("req", req_q, 1);
        check("addr", addr_q, a);
        issue_addr2 = addr2_q;
        complete(a, rdy, bc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst                        = 1'b1;
        mem_cnt                    = 0;
        imem_valid                 = 1'b0;
        branch_control             = 1'b0;
        branch_instruction_control = 1'b0;
        id_ready                   = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_instr", if_instr, 0);
        check("rst_pc", if_pc, 0);
        check("rst_flush", flush, 0);
        check("rst_misalign", misalign_err, 0);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst                        = 1'b1;
        branch_control             = 1'b0;
        branch_instruction_control = 1'b0;
        branch_target              = '0;
        imem_valid                 = 1'b0;
        imem_rdata                 = '0;
        id_ready                   = 1'b0;

        // Sequential fetch from RESET_PC; wrap on the second instance.
        do_reset();
        fetch(32'h0000_0100, 1'b1, 1'b0);
        check("wrap_first", issue_addr2, 32'hFFFF_FFFC);
        fetch(32'h0000_0104, 1'b1, 1'b0);
        check("wrap_second", issue_addr2, 32'h0000_0000);
        fetch(32'h0000_0108, 1'b1, 1'b0);

        // Branch while holding an unaccepted instruction.
        do_reset();
        fetch(32'h0000_0100, 1'b1, 1'b0);
        fetch(32'h0000_0104, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("hold_valid", if_valid, 1);
        check("hold_pc", if_pc, 32'h0000_0104);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        check("br_no_req", req_q, 0);
        check("flush_pre", flush, 0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("br_hold_clr", if_valid, 0);
        check("br_hold_flush", flush, 1);
        check("br_hold_req", req_q, 1);
        check("br_hold_addr", addr_q, 32'h0000_0200);
        complete(32'h0000_0200, 1'b1, 1'b0);

        // Condition true on a non-branch instruction: no redirect.
        fetch(32'h0000_0204, 1'b1, 1'b1);
        check("nob_flush", flush, 0);

        // Branch in WAIT, response two cycles later is dropped.
        lat = 3;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("w_addr", addr_q, 32'h0000_0208);
        cycle(1'b1, 1'b1, 32'h0000_0300, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("w_flush", flush, 1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_no_req", req_q, 0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("drop_valid", if_valid, 0);
        check("drop_req", req_q, 1);
        check("drop_addr", addr_q, 32'h0000_0300);
        complete(32'h0000_0300, 1'b1, 1'b0);

        // Second branch while draining updates the pc again.
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("d_addr", addr_q, 32'h0000_0304);
        cycle(1'b1, 1'b1, 32'h0000_0500, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0600, 1'b1);
        check("d_flush1", flush, 1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("d_flush2", flush, 1);
        check("d_no_req", req_q, 0);
        lat = 2;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("d_flush_end", flush, 0);
        check("d_req", req_q, 1);
        check("d_redir_addr", addr_q, 32'h0000_0600);
        complete(32'h0000_0600, 1'b1, 1'b0);

        // Branch coincides with the response in WAIT.
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("c_addr", addr_q, 32'h0000_0604);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0400, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("c_valid", if_valid, 0);
        check("c_pc_kept", if_pc, 32'h0000_0600);
        check("c_flush", flush, 1);
        check("c_redir_addr", addr_q, 32'h0000_0400);
        complete(32'h0000_0400, 1'b1, 1'b0);

        // Misaligned branch target while holding.
        fetch(32'h0000_0404, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0202, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("mis_valid", if_valid, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_err", misalign_err, 1);
        check("mis_flush", flush, 0);
        check("mis_req", req_q, 0);
        cycle(1'b1, 1'b1, 32'h0000_0700, 1'b1);
        repeat (3) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check("halt_req", req_q, 0);
            check("halt_flush", flush, 0);
            check("halt_err", misalign_err, 1);
        end
`else
        check("mis_err", misalign_err, 0);
        check("mis_flush", flush, 1);
        check("mis_req", req_q, 1);
        check("mis_addr", addr_q, 32'h0000_0200);
        complete(32'h0000_0200, 1'b1, 1'b0);
`endif

        // Reset in WAIT, then a stale response in the first cycle after it.
        do_reset();
        fetch(32'h0000_0100, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("r_addr", addr_q, 32'h0000_0104);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        check("async_pc", if_pc, 0);
        check("async_instr", if_instr, 0);
        check("async_valid", if_valid, 0);
        check("async_req", imem_req, 0);
        do_reset();
        inject = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("stale_req", req_q, 1);
        check("stale_addr", addr_q, 32'h0000_0100);
        complete(32'h0000_0100, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
